// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and constants for the RV32 single-port memory arbiter
package rv_mem_pkg;
    localparam int CMD_XLEN = 32;
    localparam logic [3:0] BE_FULL = 4'hF;
    typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D} arb_state_e;
    typedef struct packed {
        logic                we;
        logic [CMD_XLEN-1:0] addr;
        logic [CMD_XLEN-1:0] wdata;
        logic [3:0]          be;
    } mem_cmd_t;
    function automatic mem_cmd_t fetch_cmd(input logic [CMD_XLEN-1:0] addr);
        return '{we: 1'b0, addr: addr, wdata: '0, be: BE_FULL};
    endfunction
endpackage

// File: rtl/rv_arb_starve_cnt.sv
// rv_arb_starve_cnt: saturating count of data grants taken while a fetch is waiting
module rv_arb_starve_cnt #(
    parameter int MAX_DATA_BURST = 4,
    parameter int CNT_W = $clog2(MAX_DATA_BURST + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    logic [CNT_W-1:0] cnt;
    assign at_max = cnt == CNT_W'(MAX_DATA_BURST);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one memory port between IF fetches and MEM loads/stores,
// routes responses to their owner and raises the pipeline stall requests.
module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MAX_DATA_BURST = 4,
    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [3:0]      dm_be,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            err_spurious
);
    arb_state_e state;
    mem_cmd_t   cmd;
    logic       drop, at_max, fetch_sel, rsp_cycle, kill_i;
    assign fetch_sel = if_req & (~dm_req | at_max);
    assign rsp_cycle = if_rvalid | dm_rvalid;
    assign kill_i    = drop | if_flush;
    assign stall_if  = if_req & ~if_rvalid;
    assign stall_mem = dm_req & ~dm_rvalid;
    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_be    = cmd.be;
    rv_arb_starve_cnt #(.MAX_DATA_BURST(MAX_DATA_BURST), .CNT_W(CNT_W)) u_starve (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (state == REQ_D && mem_gnt && if_req),
        .clr    ((state == REQ_I && mem_gnt) || !if_req),
        .at_max (at_max)
    );
    // Requesters still hold their old request during the response cycle, so nothing issues then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cmd          <= '0;
            mem_req      <= 1'b0;
            drop         <= 1'b0;
            if_rvalid    <= 1'b0;
            dm_rvalid    <= 1'b0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            err_spurious <= 1'b0;
        end else begin
            if_rvalid    <= 1'b0;
            dm_rvalid    <= 1'b0;
            err_spurious <= 1'b0;
            case (state)
                IDLE: begin
                    err_spurious <= mem_rvalid;
                    if (!rsp_cycle && fetch_sel && !if_flush) begin
                        cmd     <= fetch_cmd(if_addr);
                        mem_req <= 1'b1;
                        state   <= REQ_I;
                    end else if (!rsp_cycle && !fetch_sel && dm_req) begin
                        cmd     <= '{we: dm_we, addr: dm_addr, wdata: dm_wdata, be: dm_be};
                        mem_req <= 1'b1;
                        state   <= REQ_D;
                    end
                end
                REQ_I: begin
                    err_spurious <= mem_rvalid;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        drop    <= if_flush;
                        state   <= WAIT_I;
                    end else if (if_flush) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                REQ_D: begin
                    err_spurious <= mem_rvalid;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT_D;
                    end
                end
                WAIT_I: begin
                    if (mem_rvalid) begin
                        if_rvalid <= ~kill_i;
                        if_rdata  <= kill_i ? if_rdata : mem_rdata;
                        drop      <= 1'b0;
                        state     <= IDLE;
                    end else if (if_flush) begin
                        drop <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (mem_rvalid) begin
                        dm_rvalid <= 1'b1;
                        dm_rdata  <= mem_rdata;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed scenarios followed by randomized IF/MEM traffic
// against a memory model and a transaction-level reference.
module tb_rv_mem_arbiter;
    localparam int MAXB = 4;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [3:0]  dm_be = '0;
    logic        if_rvalid, dm_rvalid, mem_req, mem_we, stall_if, stall_mem, err_spurious;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          tests = 0, failed = 0;
    int          consec, rsp_cnt, if_wait, dm_wait, n_if, n_dm;
    logic        rsp_busy, if_ret, dm_ret;
    logic [31:0] rsp_addr, a;
    logic [31:0] ref_mem [16];
    logic [31:0] mem_arr [16];

    always #5 clk = ~clk;

    rv_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err_spurious(err_spurious)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] code_val(input logic [31:0] ad);
        return (ad * 32'h9E3779B1) ^ 32'h13;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Wait for a request, grant it at once and answer it the following cycle.
    task automatic serve(input logic [31:0] rdata, output logic [31:0] ad);
        int w = 0;
        while (!mem_req && w < 20) begin
            cyc();
            w++;
        end
        chk1("serve_wait", w >= 20, 1'b0);
        ad = mem_addr;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = rdata;
        cyc();
        mem_rvalid = 1'b0;
    endtask

    task automatic new_dm();
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
        dm_wdata = $urandom;
        dm_be    = dm_we ? 4'($urandom_range(1, 15)) : 4'hF;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = 32'h01010101 * k;
            mem_arr[k] = 32'h01010101 * k;
        end
        repeat (2) cyc();
        chk("rst_ctl", 32'({mem_req, mem_we, mem_be, if_rvalid, dm_rvalid, err_spurious, stall_if, stall_mem}), 0);
        chk("rst_addr", mem_addr | mem_wdata, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        reset_n = 1'b1;
        cyc();
        // lone fetch, immediate grant
        if_req = 1'b1;
        if_addr = 32'h0;
        #1 chk1("t1_stall_if_req", stall_if, 1'b1);
        cyc();
        chk("t1_cmd", 32'({mem_req, mem_we, mem_be}), 32'h2F);
        chk("t1_addr", mem_addr, 32'h0);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        chk1("t1_req_after_gnt", mem_req, 1'b0);
        chk1("t1_stall_wait", stall_if, 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata = 32'h00000013;
        cyc();
        mem_rvalid = 1'b0;
        chk1("t1_if_rvalid", if_rvalid, 1'b1);
        chk("t1_if_rdata", if_rdata, 32'h00000013);
        chk1("t1_stall_clear", stall_if, 1'b0);
        cyc();
        chk1("t1_no_reissue", mem_req, 1'b0);
        chk1("t1_pulse_once", if_rvalid, 1'b0);
        if_req = 1'b0;
        // fetch and store together: store first
        if_req = 1'b1;
        if_addr = 32'h4;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEADBEEF;
        dm_be = 4'b0011;
        cyc();
        chk("t2_store_ctl", 32'({mem_req, mem_we, mem_be}), 32'h33);
        chk("t2_store_addr", mem_addr, 32'h100);
        chk("t2_store_wdata", mem_wdata, 32'hDEADBEEF);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0;
        cyc();
        mem_rvalid = 1'b0;
        chk1("t2_dm_rvalid", dm_rvalid, 1'b1);
        chk1("t2_if_not_yet", mem_req, 1'b0);
        cyc();
        chk1("t2_guard", mem_req, 1'b0);
        dm_req = 1'b0;
        dm_we = 1'b0;
        serve(32'h00100093, a);
        chk("t2_fetch_addr", a, 32'h4);
        chk("t2_fetch_be", 32'(mem_be), 32'hF);
        chk1("t2_if_rvalid", if_rvalid, 1'b1);
        chk("t2_if_rdata", if_rdata, 32'h00100093);
        cyc();
        // continuous data traffic with a fetch waiting
        if_addr = 32'h40;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h200;
        dm_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            serve(32'h0, a);
            chk("t3_grant_order", 32'(a == 32'h40), 32'(i % 5 == 4));
        end
        cyc();
        dm_req = 1'b0;
        if_req = 1'b0;
        cyc();
        cyc();
        // flush while the fetch is in flight
        if_req = 1'b1;
        if_addr = 32'h8;
        cyc();
        chk1("t4_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        if_flush = 1'b1;
        if_addr = 32'h80;
        cyc();
        if_flush = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        cyc();
        mem_rvalid = 1'b0;
        chk1("t4_stale_dropped", if_rvalid, 1'b0);
        serve(32'h55, a);
        chk("t4_new_pc", a, 32'h80);
        chk1("t4_if_rvalid", if_rvalid, 1'b1);
        chk("t4_if_rdata", if_rdata, 32'h55);
        cyc();
        if_req = 1'b0;
        cyc();
        // response with nothing outstanding
        mem_rvalid = 1'b1;
        cyc();
        mem_rvalid = 1'b0;
        chk1("t5_err_pulse", err_spurious, 1'b1);
        chk("t5_no_effect", 32'({mem_req, if_rvalid, dm_rvalid}), 0);
        cyc();
        chk1("t5_err_clear", err_spurious, 1'b0);
        chk1("t5_idle", mem_req, 1'b0);
        // reset in the middle of a load
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h300;
        dm_be = 4'hF;
        cyc();
        chk1("t6_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ctl", 32'({mem_req, mem_we, mem_be, if_rvalid, dm_rvalid, err_spurious}), 0);
        chk("t6_rst_addr", mem_addr, 0);
        dm_req = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h12345678;
        cyc();
        mem_rvalid = 1'b0;
        chk1("t6_late_spurious", err_spurious, 1'b1);
        chk1("t6_no_dm_rvalid", dm_rvalid, 1'b0);
        cyc();
        chk1("t6_idle", mem_req, 1'b0);
        // randomized traffic
        consec = 0; rsp_cnt = 0; if_wait = 0; dm_wait = 0; n_if = 0; n_dm = 0;
        rsp_busy = 1'b0; if_ret = 1'b0; dm_ret = 1'b0; rsp_addr = '0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            chk1("rnd_stall_if", stall_if, if_req & ~if_rvalid);
            chk1("rnd_stall_mem", stall_mem, dm_req & ~dm_rvalid);
            chk1("rnd_err", err_spurious, 1'b0);
            if (if_rvalid) begin
                n_if++;
                chk("rnd_if_owner", 32'({if_req, if_ret}), 32'h2);
                chk("rnd_if_rdata", if_rdata, code_val(if_addr));
            end
            if (dm_rvalid) begin
                n_dm++;
                chk("rnd_dm_owner", 32'({dm_req, dm_ret}), 32'h2);
                if (dm_we)
                    ref_mem[dm_addr[5:2]] = merge(ref_mem[dm_addr[5:2]], dm_wdata, dm_be);
                else
                    chk("rnd_dm_rdata", dm_rdata, ref_mem[dm_addr[5:2]]);
            end
            if_wait = (if_rvalid || !if_req) ? 0 : if_wait + 1;
            dm_wait = (dm_rvalid || !dm_req) ? 0 : dm_wait + 1;
            chk1("rnd_if_timeout", if_wait > 300, 1'b0);
            chk1("rnd_dm_timeout", dm_wait > 300, 1'b0);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (!if_req) consec = 0;
            if (rsp_busy) begin
                if (rsp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rsp_addr < 32'h1000 ? code_val(rsp_addr) : mem_arr[rsp_addr[5:2]];
                    rsp_busy = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end else if (mem_req && $urandom_range(0, 2) != 0) begin
                mem_gnt = 1'b1;
                rsp_busy = 1'b1;
                rsp_cnt = int'($urandom_range(0, 2));
                rsp_addr = mem_addr;
                if (mem_addr < 32'h1000) begin
                    chk("rnd_fetch_addr", mem_addr, if_addr);
                    chk("rnd_fetch_ctl", 32'({mem_we, mem_be}), 32'hF);
                    consec = 0;
                end else begin
                    chk("rnd_dm_addr", mem_addr, dm_addr);
                    chk("rnd_dm_ctl", 32'({mem_we, mem_be}), 32'({dm_we, dm_be}));
                    if (mem_we) begin
                        chk("rnd_dm_wdata", mem_wdata, dm_wdata);
                        mem_arr[mem_addr[5:2]] = merge(mem_arr[mem_addr[5:2]], mem_wdata, mem_be);
                    end
                    if (if_req) consec++;
                    chk1("rnd_burst_limit", consec > MAXB, 1'b0);
                end
            end
            if_flush = 1'b0;
            if (if_ret) begin
                if_ret = 1'b0;
                if_req = $urandom_range(0, 3) != 0;
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end else if (if_rvalid) begin
                if_ret = 1'b1;
            end else if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req = 1'b1;
                    if_addr = 32'($urandom_range(0, 255)) << 2;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_flush = 1'b1;
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (dm_ret) begin
                dm_ret = 1'b0;
                if ($urandom_range(0, 3) != 0) new_dm();
                else dm_req = 1'b0;
            end else if (dm_rvalid) begin
                dm_ret = 1'b1;
            end else if (!dm_req && $urandom_range(0, 1) == 0) begin
                new_dm();
            end
        end
        chk1("rnd_activity", n_if > 20 && n_dm > 20, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
